// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB stage and its load alignment helper.
package mem_wb_stage_pkg;

  // Load type encodings carried from MEM into WB.
  localparam logic [2:0] LdNone = 3'd0;
  localparam logic [2:0] LdLb   = 3'd1;
  localparam logic [2:0] LdLbu  = 3'd2;
  localparam logic [2:0] LdLh   = 3'd3;
  localparam logic [2:0] LdLhu  = 3'd4;
  localparam logic [2:0] LdLw   = 3'd5;

  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [4:0]  NopRegAddr = 5'd0;
  localparam logic [31:0] ZeroWord   = 32'd0;

  // One instruction's worth of state held in the MEM/WB register.
  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
  } wb_entry_t;

  // Empty slot: no write, no load, not counted as retired.
  function automatic wb_entry_t bubble_entry();
    wb_entry_t e;
    e.valid   = 1'b0;
    e.wreg    = ~WriteEnable;
    e.wd      = NopRegAddr;
    e.wdata   = ZeroWord;
    e.ld_type = LdNone;
    e.addr_lo = 2'd0;
    return e;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the addressed byte/half/word out of a big-endian RAM word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Select the addressed byte and half-word; offset 0 is the most significant lane.
  always_comb begin
    sel_byte = word[31:24];
    unique case (addr_lo)
      2'd0: sel_byte = word[31:24];
      2'd1: sel_byte = word[23:16];
      2'd2: sel_byte = word[15:8];
      2'd3: sel_byte = word[7:0];
      default: sel_byte = word[31:24];
    endcase
    // Misaligned halves are trapped upstream, so only bit 1 matters here.
    sel_half = addr_lo[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    result = word;
    case (ld_type)
      LdLb:    result = {{24{sel_byte[7]}}, sel_byte};
      LdLbu:   result = {24'd0, sel_byte};
      LdLh:    result = {{16{sel_half[15]}}, sel_half};
      LdLhu:   result = {16'd0, sel_half};
      LdLw:    result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: latches MEM results, honours
// stall/flush, aligns synchronous RAM load data and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [4:0]       mem_wd,
  input  logic             mem_wreg,
  input  logic [31:0]      mem_wdata,
  input  logic [2:0]       mem_ld_type,
  input  logic [1:0]       mem_addr_lo,
  input  logic [31:0]      ram_rdata,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic [CNT_W-1:0] retired_cnt
);

  wb_entry_t        entry_q, entry_d;
  logic             hold_q, hold_d;
  logic [31:0]      hold_word_q, hold_word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        wb_stop;
  logic        mem_stop;
  logic [31:0] load_word;
  logic [31:0] aligned;

  // Earlier stages' stall bits are of no concern to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  assign wb_stop  = (stall[5] == Stop);
  assign mem_stop = (stall[4] == Stop) && (stall[5] == NoStop);

  // Next-state for the pipeline entry, load-data hold and retired counter.
  always_comb begin
    entry_d     = entry_q;
    hold_d      = hold_q;
    hold_word_d = hold_word_q;
    cnt_d       = cnt_q;

    if (flush || mem_stop) begin
      entry_d = bubble_entry();
    end else if (!wb_stop) begin
      entry_d.valid   = mem_valid;
      entry_d.wreg    = mem_wreg;
      entry_d.wd      = mem_wd;
      entry_d.wdata   = mem_wdata;
      entry_d.ld_type = mem_ld_type;
      entry_d.addr_lo = mem_addr_lo;
    end

    // RAM output may drift while WB is stalled, so freeze it on the first stalled edge.
    if (flush || !wb_stop) begin
      hold_d = 1'b0;
    end else if (!hold_q && (entry_q.ld_type != LdNone)) begin
      hold_d      = 1'b1;
      hold_word_d = ram_rdata;
    end

    if (entry_q.valid && !wb_stop && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      entry_q     <= bubble_entry();
      hold_q      <= 1'b0;
      hold_word_q <= ZeroWord;
      cnt_q       <= '0;
    end else begin
      entry_q     <= entry_d;
      hold_q      <= hold_d;
      hold_word_q <= hold_word_d;
      cnt_q       <= cnt_d;
    end
  end

  assign load_word = hold_q ? hold_word_q : ram_rdata;

  mem_wb_stage_load_align u_load_align (
    .ld_type (entry_q.ld_type),
    .addr_lo (entry_q.addr_lo),
    .word    (load_word),
    .result  (aligned)
  );

  // Register-file write port; repeats the same write every held cycle.
  always_comb begin
    wb_we       = (entry_q.wreg == WriteEnable) && entry_q.valid;
    wb_waddr    = entry_q.wd;
    wb_wdata    = (entry_q.ld_type != LdNone) ? aligned : entry_q.wdata;
    retired_cnt = cnt_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus random bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] ram_rdata;

  logic        wb_we, we4;
  logic [4:0]  wb_waddr, waddr4;
  logic [31:0] wb_wdata, wdata4;
  logic [31:0] retired_cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .ram_rdata(ram_rdata), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .retired_cnt(retired_cnt)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .ram_rdata(ram_rdata), .wb_we(we4), .wb_waddr(waddr4),
    .wb_wdata(wdata4), .retired_cnt(cnt4)
  );

  // Behavioural model: contents of the WB slot, held RAM word, retired count.
  logic        m_valid, m_wreg;
  logic [4:0]  m_wd;
  logic [31:0] m_wdata;
  int          m_ld;
  int          m_lo;
  logic        m_held;
  logic [31:0] m_hword;
  int unsigned m_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Arithmetic view of big-endian sub-word extraction.
  function automatic logic [31:0] align_model(int ld, int lo, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - lo))) & 32'hFF;
    h = (w >> (16 * (1 - lo / 2))) & 32'hFFFF;
    case (ld)
      1: return (b >= 32'h80) ? b - 32'h100 : b;
      2: return b;
      3: return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      4: return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] w;
    logic [31:0] exp_data;
    w = m_held ? m_hword : ram_rdata;
    exp_data = (m_ld == 0) ? m_wdata : align_model(m_ld, m_lo, w);
    chk("we", {31'd0, wb_we}, {31'd0, m_valid & m_wreg});
    chk("waddr", {27'd0, wb_waddr}, {27'd0, m_wd});
    chk("wdata", wb_wdata, exp_data);
    chk("cnt", retired_cnt, m_cnt);
    chk("cnt4", {28'd0, cnt4}, m_cnt % 16);
  endtask

  task automatic model_edge();
    if (rst) begin
      {m_valid, m_wreg, m_wd, m_wdata} = '0;
      m_ld = 0; m_lo = 0; m_held = 1'b0; m_hword = '0; m_cnt = 0;
    end else begin
      if (m_valid && !stall[5] && !flush) m_cnt++;
      if (flush || !stall[5]) m_held = 1'b0;
      else if (!m_held && m_ld != 0) begin
        m_held = 1'b1;
        m_hword = ram_rdata;
      end
      if (flush || (stall[4] && !stall[5])) begin
        m_valid = 1'b0; m_wreg = 1'b0; m_wd = '0; m_wdata = '0; m_ld = 0; m_lo = 0;
      end else if (!stall[5]) begin
        m_valid = mem_valid; m_wreg = mem_wreg; m_wd = mem_wd; m_wdata = mem_wdata;
        m_ld = int'(mem_ld_type); m_lo = int'(mem_addr_lo);
      end
    end
  endtask

  // Check current outputs, then advance one clock and update the model.
  task automatic cyc();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] wd, input logic wr,
                         input logic [31:0] d, input logic [2:0] ld, input logic [1:0] lo);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = d;
    mem_ld_type = ld; mem_addr_lo = lo;
  endtask

  logic [31:0] cnt_snap;
  logic [2:0]  ld_tab [6];
  logic [1:0]  lo_tab [6];
  logic [31:0] exp_tab[6];
  int          tries;
  logic [2:0]  rld;

  initial begin
    ld_tab = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
    lo_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    exp_tab = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_0001,
                32'h0000_0080, 32'h0000_7F01};

    // Reset with a would-be write in MEM.
    rst = 1'b1; stall = '0; flush = 1'b0; ram_rdata = '0;
    set_mem(1'b1, 5'd7, 1'b1, 32'hFFFF_FFFF, 3'd0, 2'd0);
    @(posedge clk); model_edge(); #1;
    cyc();
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);

    // First ALU op after release.
    rst = 1'b0;
    set_mem(1'b1, 5'd5, 1'b1, 32'h1234_5678, 3'd0, 2'd0);
    cyc();
    set_mem(1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 2'd0);
    chk("alu_we", {31'd0, wb_we}, 32'd1);
    chk("alu_waddr", {27'd0, wb_waddr}, 32'd5);
    chk("alu_wdata", wb_wdata, 32'h1234_5678);
    cyc();
    chk("alu_cnt", retired_cnt, 32'd1);

    // Byte/half loads from a fixed RAM word.
    ram_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 6; i++) begin
      set_mem(1'b1, 5'd10 + 5'(i), 1'b1, 32'h0, ld_tab[i], lo_tab[i]);
      cyc();
      chk("ld_align", wb_wdata, exp_tab[i]);
    end
    set_mem(1'b1, 5'd11, 1'b1, 32'h0, 3'd4, 2'd0);
    cyc();
    chk("lhu0", wb_wdata, 32'h0000_80FF);

    // WB stall holding a load while the RAM output changes.
    ram_rdata = 32'h1122_3344;
    set_mem(1'b1, 5'd9, 1'b1, 32'h0, 3'd5, 2'd0);
    cyc();
    set_mem(1'b1, 5'd12, 1'b1, 32'h5555_0000, 3'd0, 2'd0);
    cnt_snap = retired_cnt;
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      ram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("hold_wdata", wb_wdata, 32'h1122_3344);
      chk("hold_cnt", retired_cnt, cnt_snap);
    end
    stall = 6'b000000;
    cyc();
    chk("hold_release_cnt", retired_cnt, cnt_snap + 32'd1);
    set_mem(1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 2'd0);
    cyc();

    // MEM stall inserts bubbles, then the held MEM op lands.
    cnt_snap = retired_cnt;
    set_mem(1'b1, 5'd6, 1'b1, 32'h0000_00AA, 3'd0, 2'd0);
    stall = 6'b010000;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("memstall_we", {31'd0, wb_we}, 32'd0);
    end
    stall = 6'b000000;
    cyc();
    set_mem(1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 2'd0);
    chk("memstall_waddr", {27'd0, wb_waddr}, 32'd6);
    cyc();
    chk("memstall_cnt", retired_cnt, cnt_snap + 32'd1);

    // Flush kills the instruction entering WB.
    cnt_snap = retired_cnt;
    set_mem(1'b1, 5'd3, 1'b1, 32'h3333_3333, 3'd0, 2'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    set_mem(1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 2'd0);
    chk("flush_we", {31'd0, wb_we}, 32'd0);
    cyc();
    chk("flush_cnt", retired_cnt, cnt_snap);

    // Flush together with a WB stall while holding a load.
    ram_rdata = 32'hCAFE_F00D;
    set_mem(1'b1, 5'd4, 1'b1, 32'h0, 3'd5, 2'd0);
    cyc();
    stall = 6'b110000;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; stall = 6'b000000;
    chk("flush_stall_we", {31'd0, wb_we}, 32'd0);
    cyc();

    // Counter wrap on the 4-bit instance.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_mem(1'b1, 5'(i), 1'b1, 32'(i), 3'd0, 2'd0);
      cyc();
    end
    set_mem(1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 2'd0);
    cyc();
    chk("wrap_cnt4", {28'd0, cnt4}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 4'($urandom)};
      rld   = 3'($urandom_range(0, 5));
      set_mem(1'($urandom), 5'($urandom), 1'($urandom), $urandom, rld, 2'($urandom));
      if (rld == 3'd3 || rld == 3'd4) mem_addr_lo[0] = 1'b0;
      if (rld == 3'd5) mem_addr_lo = 2'd0;
      ram_rdata = $urandom;
      cyc();
    end
    rst = 1'b0; flush = 1'b0; stall = '0;
    tries = 0;
    cyc();
    tries++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back stage of the 5-stage MIPS core.
- Latches MEM-stage results, honours the per-stage stall vector and flush, and aligns load data returned by the synchronous data RAM.
- Drives the register-file write port (we/waddr/wdata); the same values feed the register file's same-cycle write-to-read bypass.
- Keeps a retired-instruction counter for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high (RstEnable = 1'b1)
- stall  input  6  per-stage stall vector; bit4 = MEM, bit5 = WB (1 = Stop)
- flush  input  1  exception flush; kills the instruction entering WB
- mem_valid  input  1  MEM holds a real instruction (0 = bubble)
- mem_wd  input  5  destination register address
- mem_wreg  input  1  destination write enable
- mem_wdata  input  32  ALU/move result (non-load)
- mem_ld_type  input  3  LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW
- mem_addr_lo  input  2  byte offset of load address
- ram_rdata  input  32  sync data-RAM read word, valid in the cycle after MEM
- wb_we  output  1  to regfile we
- wb_waddr  output  5  to regfile waddr
- wb_wdata  output  32  to regfile wdata
- retired_cnt  output  CNT_W  count of instructions completed in WB

Behaviour:
- Reset, checked synchronously at posedge clk with rst=1:
  - all pipeline registers cleared; wb_we=0, wb_waddr=0, wb_wdata=0, retired_cnt=0.
  - Reset mid-stall or mid-hold discards the held entry.
- Register update priority at each posedge, highest first:
  1. rst
  2. flush → bubble
  3. stall[4]=1 and stall[5]=0 → bubble
  4. stall[5]=1 → hold all registers
  5. otherwise latch mem_* inputs
- A bubble means valid=0, wreg=0, wd=0, ld_type=LD_NONE.
- Latency: one cycle from MEM to WB outputs. Load data arrives combinationally from ram_rdata in the WB cycle; there is no extra cycle.
- Load-data hold:
  - On the first cycle WB is stalled while holding a load, capture ram_rdata into a hold register and set a hold flag.
  - While the flag is set, alignment uses the held word, because the RAM output is not guaranteed stable under stall.
  - The flag clears when WB advances, on flush, or on rst.
- Alignment is big-endian; the selected byte/half comes from ram_rdata:
  - byte: offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0]
  - half: offset 0 → [31:16], 2 → [15:0]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Misaligned LH/LHU/LW never reach this block (caught in MEM as an exception).
- Outputs:
  - wb_wdata = aligned load data when ld_type != LD_NONE, else the latched wdata.
  - wb_we = latched wreg and valid.
  - wb_waddr = latched wd.
  - An address of 0 is passed through unchanged; the register file ignores writes to $0.
- While WB holds, outputs stay constant, so the same write repeats each held cycle (idempotent).
- retired_cnt increments by 1 on each posedge where valid=1, stall[5]=0, rst=0 and flush=0.
  - The increment is taken in the same cycle WB advances.
  - Wraps modulo 2^CNT_W with no saturation.
- Simultaneous flush and stall[5]: flush wins; the entry becomes a bubble and is not counted.

Decomposition:
- Shared include, alongside the existing global defines:
  - LD_* encodings (3-bit)
  - Stop/NoStop
  - RstEnable, WriteEnable
  - NOPRegAddr, ZeroWord
- One natural sub-module: load_align (combinational: ld_type, addr_lo, word → 32-bit result). It is reused later by the MEM-stage store/forwarding checks.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_wreg=1 → wb_we=0, wb_wdata=0, retired_cnt=0; first valid ALU op after release (wd=5, wdata=0x1234_5678) appears on wb_* one cycle later with we=1, and retired_cnt=1 the following cycle.
- Byte loads: ram_rdata=0x80FF_7F01, LB at offsets 0..3 → 0xFFFF_FF80, 0xFFFF_FFFF, 0x0000_007F, 0x0000_0001; LBU at offset 0 → 0x0000_0080; LH at offset 2 → 0x0000_7F01; LHU at offset 0 → 0x0000_80FF.
- WB stall hold: LW issued, stall[5]=1 for 3 cycles, ram_rdata changed to 0xDEAD_BEEF after cycle 1 → wb_wdata holds the original word for all 3 cycles; retired_cnt unchanged until release, then +1.
- MEM stall bubble: stall=6'b010000 for 2 cycles → wb_we=0 in both cycles; the held MEM instruction lands after release; counter +1 only.
- Flush: flush=1 with a valid write (wd=3) in MEM → next cycle wb_we=0, counter not incremented. Flush together with stall[5]=1 → bubble and hold flag cleared.
- Counter wrap: CNT_W=4, 17 back-to-back valid ops → retired_cnt reads 1.
